hex_counter_seg7: RTL and testbench
===================================

Name: hex_counter_seg7

Overview:
- 4-bit up/down hexadecimal counter advanced by an internal clock-enable prescaler.
- Drives a common-anode (active-low) 7-segment display.
- Top-level of the counter/display block; outputs feed board pins and debug.
- The seven-segment decode is purely combinational from the count register.

Parameters:
- DIV_COUNT, default 10: clock cycles per count step; legal values 2 or more.
- PRE_W, default $clog2(DIV_COUNT): prescaler width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  1 = counting allowed; 0 = hold count.
- upDown  input  1  1 = count up; 0 = count down.
- count  output  4  current counter value, registered.
- seg7  output  7  segments {a,b,c,d,e,f,g}; bit 6 = a, bit 0 = g; active-low (0 = lit).

Behaviour:
- One clock domain; reset is asynchronous and active-low (clk, rst).
- Reset values while rst=0: prescaler 0, count 4'h0, seg7 7'b0000001.
- Prescaler:
  - Increments every clk edge from 0 to DIV_COUNT-1, then wraps to 0.
  - Runs regardless of enable.
  - tick = (prescaler == DIV_COUNT-1).
- Count update, on a clk edge with tick=1:
  - enable=1 and upDown=1: count +1, modulo 16 (F -> 0).
  - enable=1 and upDown=0: count -1, modulo 16 (0 -> F).
  - enable=0: count holds.
- enable and upDown are sampled only at tick edges; changes between ticks have no effect.
- Timing after rst deasserts: first count change on the DIV_COUNT-th rising edge; thereafter every DIV_COUNT edges (20 ns at 2 ns clock with default).
- seg7 = decode(count), combinational, zero-cycle latency.
- Decode table, hex: value = seg7 bits:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Reset asserted mid-count: count and prescaler clear immediately (asynchronous).
- After reset release, the prescaler restarts from 0.

Optional Feature:
- Macro SEG7_ACTIVE_HIGH_EN.
- Defined: seg7 is the bitwise inverse of the table above (common-cathode). Reset value is then 7'b1111110.
- Undefined: active-low table as specified.
- count is unaffected either way.

Decomposition:
- Package hex_counter_seg7_pkg:
  - 16-entry active-low segment constant array indexed by count.
  - Constants SEG_BLANK (7'b1111111) and DEFAULT_DIV_COUNT (10).
- Sub-module seg7_hex_decoder:
  - Combinational 4-bit to 7-bit decode using the package table.
  - Applies SEG7_ACTIVE_HIGH_EN inversion.
- Prescaler and counter remain in hex_counter_seg7.

Test Plan:
- Reset: hold rst=0 for 5 cycles with enable=1 -> count=0, seg7=0000001 throughout; no change until the 10th edge after release.
- Count up (DIV_COUNT=10, 2 ns clock): rst=1 at 10 ns, enable=1, upDown=1; sample every 20 ns mid-window -> count 0,1,...,F with seg7 matching the table (A=0001000, F=0111000); next step wraps to 0 / 0000001.
- Count down: from count=2 set upDown=0 -> 1, 0, F (0111000), E (0110000) on successive ticks.
- Hold: enable=0 at count=5 for 3 ticks -> count stays 5, seg7 stays 0100100; re-enable -> 6 on the next tick.
- Mid-period input toggles: toggle upDown several times between ticks, final value 1 at the tick -> exactly one increment; async reset pulse mid-window -> count=0 immediately, before the next clk edge.
- SEG7_ACTIVE_HIGH_EN build: count=8 -> seg7=1111111; count=1 -> seg7=0110000.

Source files
------------

// File: rtl/hex_counter_seg7_pkg.sv
// hex_counter_seg7_pkg: shared constants for the hex counter / 7-segment block.
//   SEG_TABLE         16-entry active-low segment patterns {a,b,c,d,e,f,g}, indexed by count
//   SEG_BLANK         all segments dark in active-low form
//   DEFAULT_DIV_COUNT default prescaler period in clock cycles
package hex_counter_seg7_pkg;

  localparam int unsigned DEFAULT_DIV_COUNT = 10;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Bit 6 = a ... bit 0 = g; 0 lights a segment (common anode).
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: combinational 4-bit hex to 7-segment decode.
//   value  in   4  hex digit to display
//   seg    out  7  segments {a,b,c,d,e,f,g}
// Build option: SEG7_ACTIVE_HIGH_EN selects common-cathode (active-high) segment polarity;
// undefined gives the common-anode (active-low) patterns.
module seg7_hex_decoder
  import hex_counter_seg7_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
`ifdef SEG7_ACTIVE_HIGH_EN
    // XOR with the all-dark pattern inverts every segment.
    seg = SEG_TABLE[value] ^ SEG_BLANK;
`else
    seg = SEG_TABLE[value];
`endif
  end

endmodule

// File: rtl/hex_counter_seg7.sv
// hex_counter_seg7: 4-bit up/down hex counter stepped by an internal prescaler tick,
// driving a 7-segment display.
//   clk     in   1  system clock, rising edge
//   rst     in   1  asynchronous active-low reset
//   enable  in   1  1 = count on tick, 0 = hold
//   upDown  in   1  1 = count up, 0 = count down
//   count   out  4  registered counter value
//   seg7    out  7  segments {a,b,c,d,e,f,g}, decoded combinationally from count
// Build option: SEG7_ACTIVE_HIGH_EN inverts seg7 polarity (handled in seg7_hex_decoder).
module hex_counter_seg7
  import hex_counter_seg7_pkg::*;
#(
  parameter int unsigned DIV_COUNT = DEFAULT_DIV_COUNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       upDown,
  output logic [3:0] count,
  output logic [6:0] seg7
);

  // Derived width; guarded so an illegal DIV_COUNT < 2 still elaborates.
  localparam int unsigned PRE_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_COUNT - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       count_q, count_d;
  logic             tick;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
  end

  // enable/upDown only matter on the tick cycle.
  always_comb begin
    count_d = count_q;
    if (tick && enable) begin
      count_d = upDown ? count_q + 4'd1 : count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q   <= '0;
      count_q <= 4'h0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

  seg7_hex_decoder u_decoder (
    .value (count_q),
    .seg   (seg7)
  );

endmodule

// File: tb/tb_hex_counter_seg7.sv
// tb_hex_counter_seg7: self-checking bench for hex_counter_seg7 (DIV_COUNT = 10, 2 ns clock).
// Table-driven tick vectors plus hand-written sequences for reset timing, mid-window input
// toggles and asynchronous reset. Honours SEG7_ACTIVE_HIGH_EN for expected segment polarity.
module tb_hex_counter_seg7;
  timeunit 1ns;
  timeprecision 100ps;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       enable = 1'b0;
  logic       upDown = 1'b1;
  logic [3:0] count;
  logic [6:0] seg7;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [3:0] cnt;
  } exp_t;

  typedef struct {
    logic       en;
    logic       ud;
    logic [3:0] cnt;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];

  hex_counter_seg7 #(
    .DIV_COUNT (10)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .upDown (upDown),
    .count  (count),
    .seg7   (seg7)
  );

  always #1 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
`ifdef SEG7_ACTIVE_HIGH_EN
    s = ~s;
`endif
    return s;
  endfunction

  task automatic push(input string name, input logic [3:0] cnt);
    exp_t e;
    e.name = name;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got count=%h seg7=%b, required a queued expectation",
               count, seg7);
    end else begin
      e = exp_q.pop_front();
      if (count !== e.cnt) begin
        n_bad++;
        $display("FAIL %s count: got %h, required %h", e.name, count, e.cnt);
      end
      n_cmp++;
      if (seg7 !== ref_seg(e.cnt)) begin
        n_bad++;
        $display("FAIL %s seg7: got %b, required %b", e.name, seg7, ref_seg(e.cnt));
      end
    end
  endtask

  // Advance n rising edges, then settle half a cycle away from the edge.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #0.5;
  endtask

  task automatic add_vec(input logic en, input logic ud, input logic [3:0] cnt);
    vec_t v;
    v.en  = en;
    v.ud  = ud;
    v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] c;

    // Vectors applied one per tick, starting from count = 1.
    for (int v = 2; v < 16; v++) add_vec(1'b1, 1'b1, 4'(v));
    add_vec(1'b1, 1'b1, 4'h0);  // F -> 0 wrap
    add_vec(1'b1, 1'b1, 4'h1);
    add_vec(1'b1, 1'b1, 4'h2);
    add_vec(1'b1, 1'b0, 4'h1);
    add_vec(1'b1, 1'b0, 4'h0);
    add_vec(1'b1, 1'b0, 4'hF);  // 0 -> F wrap
    add_vec(1'b1, 1'b0, 4'hE);
    c = 4'hE;
    for (int i = 0; i < 7; i++) begin
      c = c + 4'd1;
      add_vec(1'b1, 1'b1, c);   // climbs to 5
    end
    add_vec(1'b0, 1'b1, 4'h5);  // hold
    add_vec(1'b0, 1'b0, 4'h5);
    add_vec(1'b0, 1'b1, 4'h5);
    add_vec(1'b1, 1'b1, 4'h6);  // re-enable

    // Reset held with enable=1: count stays 0.
    rst    = 1'b0;
    enable = 1'b1;
    upDown = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edges(1);
      push("reset_hold", 4'h0);
      pop_check();
    end

    // Release away from an edge; first step lands on the 10th rising edge.
    @(negedge clk);
    rst = 1'b1;
    edges(9);
    push("pre_first_tick", 4'h0);
    pop_check();
    edges(1);
    push("first_tick", 4'h1);
    pop_check();

    foreach (vecs[i]) begin
      enable = vecs[i].en;
      upDown = vecs[i].ud;
      push($sformatf("vec%0d", i), vecs[i].cnt);
      edges(10);
      pop_check();
    end

    // upDown/enable glitching between ticks; only the tick-edge value matters (6 -> 7).
    push("updown_toggle", 4'h7);
    upDown = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #0.3;
      upDown = ~upDown;
      enable = i[0];
    end
    upDown = 1'b1;
    enable = 1'b1;
    edges(2);
    pop_check();

    // enable pulses mid-window but is low at the tick: hold at 7.
    push("enable_glitch_hold", 4'h7);
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #0.3;
      enable = ~i[0];
    end
    enable = 1'b0;
    edges(2);
    pop_check();

    // Async reset mid-window clears before any further clock edge.
    enable = 1'b1;
    upDown = 1'b1;
    repeat (3) @(posedge clk);
    #0.4;
    rst = 1'b0;
    #0.2;
    push("async_reset", 4'h0);
    pop_check();

    // Prescaler restarts from 0 after release.
    @(negedge clk);
    rst = 1'b1;
    edges(9);
    push("post_reset_pre_tick", 4'h0);
    pop_check();
    edges(1);
    push("post_reset_tick", 4'h1);
    pop_check();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d pending, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
